// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch bus bundle: the instruction-memory read port and the
// instruction-register handoff to decode. The fetch unit is the master;
// memory and decode together sit on the slave side.
interface instruction_fetch_unit_if;
    logic [15:0] IMEM_ADDR;
    logic        IMEM_REQ;
    logic        IMEM_ACK;
    logic [15:0] IMEM_DATA;
    logic [15:0] IR_OUT;
    logic        IR_VALID;
    logic        IR_READY;

    modport master (
        output IMEM_ADDR,
        output IMEM_REQ,
        input  IMEM_ACK,
        input  IMEM_DATA,
        output IR_OUT,
        output IR_VALID,
        input  IR_READY
    );

    modport slave (
        input  IMEM_ADDR,
        input  IMEM_REQ,
        output IMEM_ACK,
        output IMEM_DATA,
        input  IR_OUT,
        input  IR_VALID,
        output IR_READY
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit. Drives an external program counter through
// PC_IN/C_PCWrite, reads instruction memory at the current PC and hands
// each fetched word to decode through a valid/ready instruction register.
// Branch redirects may arrive at any time after boot; a fetch already in
// flight when a redirect arrives is allowed to complete and its data is
// thrown away (the KILL flag remembers that).
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] PC_OUT,
    output logic [15:0] PC_IN,
    output logic        C_PCWrite,
    input  logic        C_Branch,
    input  logic [15:0] BRANCH_TARGET,
    instruction_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        WRITE = 2'd1,
        FETCH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        kill;
    logic        kill_next;
    logic [15:0] pc_in;
    logic [15:0] pc_in_next;
    logic        pc_write;
    logic        pc_write_next;
    logic [15:0] ir_out;
    logic [15:0] ir_out_next;
    logic        ir_valid;
    logic        ir_valid_next;
    logic        transfer;

    // Decode takes the held instruction on any edge where both sides agree.
    assign transfer = ir_valid && bus.IR_READY;

    // The memory always reads at the PC the program counter currently shows,
    // and the request is simply "we are in FETCH", so reset drops it at once.
    assign bus.IMEM_ADDR = PC_OUT;
    assign bus.IMEM_REQ  = (state == FETCH);
    assign bus.IR_OUT    = ir_out;
    assign bus.IR_VALID  = ir_valid;
    assign PC_IN         = pc_in;
    assign C_PCWrite     = pc_write;

    // Next-state and next-register values; everything holds unless a case
    // below says otherwise.
    always_comb begin
        state_next    = state;
        kill_next     = kill;
        pc_in_next    = pc_in;
        pc_write_next = pc_write;
        ir_out_next   = ir_out;
        ir_valid_next = ir_valid;

        case (state)
            // PC_IN already holds the reset vector; just ask the PC to load it.
            // Redirects this early are ignored on purpose.
            BOOT: begin
                pc_write_next = 1'b1;
                state_next    = WRITE;
            end

            // The PC loads PC_IN at the end of this cycle. A redirect here
            // overwrites PC_IN and buys one more load cycle.
            WRITE: begin
                if (C_Branch) begin
                    pc_in_next    = BRANCH_TARGET;
                    pc_write_next = 1'b1;
                end else begin
                    pc_write_next = 1'b0;
                    state_next    = FETCH;
                end
            end

            // Hold the request until memory answers. Once started the read is
            // never abandoned; a redirect only marks its result as unwanted.
            FETCH: begin
                if (bus.IMEM_ACK) begin
                    kill_next     = 1'b0;
                    pc_write_next = 1'b1;
                    state_next    = WRITE;
                    if (C_Branch) begin
                        pc_in_next = BRANCH_TARGET;
                    end else if (!kill) begin
                        ir_out_next   = bus.IMEM_DATA;
                        ir_valid_next = 1'b1;
                        pc_in_next    = PC_OUT + 16'd1;
                        state_next    = HOLD;
                    end
                end else if (C_Branch) begin
                    pc_in_next = BRANCH_TARGET;
                    kill_next  = 1'b1;
                end
            end

            // The PC+1 load happens on the first HOLD edge, so decode may take
            // the instruction on that same edge and the next FETCH still sees
            // the advanced PC. A redirect wins over sequential flow, but an
            // instruction accepted on the redirect edge still counts as taken.
            HOLD: begin
                pc_write_next = 1'b0;
                if (C_Branch) begin
                    pc_in_next    = BRANCH_TARGET;
                    pc_write_next = 1'b1;
                    ir_valid_next = 1'b0;
                    state_next    = WRITE;
                end else if (transfer) begin
                    ir_valid_next = 1'b0;
                    state_next    = FETCH;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            kill     <= 1'b0;
            pc_in    <= RESET_VECTOR;
            pc_write <= 1'b0;
            ir_out   <= 16'h0000;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_next;
            kill     <= kill_next;
            pc_in    <= pc_in_next;
            pc_write <= pc_write_next;
            ir_out   <= ir_out_next;
            ir_valid <= ir_valid_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: models the program counter and an
// instruction memory with programmable answer latency, runs directed
// scenarios, then a randomized stream checked against a program-flow model
// (sequential addresses, redirected by branches).
module tb_instruction_fetch_unit;

    localparam logic [15:0] RV = 16'h0010;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_out;
    logic [15:0] PC_IN;
    logic        C_PCWrite;
    logic        C_Branch;
    logic [15:0] BRANCH_TARGET;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC_OUT        (pc_out),
        .PC_IN         (PC_IN),
        .C_PCWrite     (C_PCWrite),
        .C_Branch      (C_Branch),
        .BRANCH_TARGET (BRANCH_TARGET),
        .bus           (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          ack_delay    = 0;
    int          req_cycles   = 0;
    logic        use_fixed    = 1'b0;
    logic [15:0] fixed_data   = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External program counter: loads PC_IN whenever the fetch unit asks.
    initial pc_out = 16'h0000;
    always @(posedge clk) begin
        if (C_PCWrite) pc_out <= PC_IN;
    end

    // Instruction memory contents: a bijective scramble of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h5A5A;
    endfunction

    // Decide the memory answer for the coming edge, then advance one cycle
    // and settle just after the edge.
    task automatic step();
        if (!bus.IMEM_REQ) begin
            req_cycles   = 0;
            bus.IMEM_ACK = 1'b0;
        end else begin
            if (req_cycles >= ack_delay) begin
                bus.IMEM_ACK  = 1'b1;
                bus.IMEM_DATA = use_fixed ? fixed_data : mem_word(bus.IMEM_ADDR);
            end else begin
                bus.IMEM_ACK = 1'b0;
            end
            req_cycles++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (PC_IN !== RV) begin tests_failed++; $display("[TB] FAIL reset_pc_in: got %h expected %h", PC_IN, RV); end
        tests_run++;
        if (C_PCWrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pcwrite: got %b expected 0", C_PCWrite); end
        tests_run++;
        if (bus.IR_OUT !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_ir_out: got %h expected 0000", bus.IR_OUT); end
        tests_run++;
        if (bus.IR_VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ir_valid: got %b expected 0", bus.IR_VALID); end
        tests_run++;
        if (bus.IMEM_REQ !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_imem_req: got %b expected 0", bus.IMEM_REQ); end
        @(posedge clk);
        #1;
        tests_run++;
        if (C_PCWrite !== 1'b0 || bus.IMEM_REQ !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_clocked: got pcwrite=%b req=%b expected 0/0", C_PCWrite, bus.IMEM_REQ);
        end
    endtask

    task automatic test_first_fetch();
        use_fixed  = 1'b1;
        fixed_data = 16'hA5A5;
        ack_delay  = 1;
        bus.IR_READY = 1'b1;
        rst_n = 1'b1;
        step();
        tests_run++;
        if (C_PCWrite !== 1'b1 || PC_IN !== RV) begin
            tests_failed++;
            $display("[TB] FAIL boot_write: got pcwrite=%b pc_in=%h expected 1/%h", C_PCWrite, PC_IN, RV);
        end
        step();
        tests_run++;
        if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== RV || C_PCWrite !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL first_fetch_req: got req=%b addr=%h pcwrite=%b expected 1/%h/0", bus.IMEM_REQ, bus.IMEM_ADDR, C_PCWrite, RV);
        end
        step();
        tests_run++;
        if (bus.IMEM_REQ !== 1'b1 || bus.IR_VALID !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fetch_wait: got req=%b valid=%b expected 1/0", bus.IMEM_REQ, bus.IR_VALID);
        end
        step();
        tests_run++;
        if (bus.IR_OUT !== 16'hA5A5 || bus.IR_VALID !== 1'b1 || PC_IN !== 16'h0011 || C_PCWrite !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL first_ack: got ir=%h valid=%b pc_in=%h pcwrite=%b expected a5a5/1/0011/1", bus.IR_OUT, bus.IR_VALID, PC_IN, C_PCWrite);
        end
        step();
        tests_run++;
        if (bus.IR_VALID !== 1'b0 || bus.IMEM_ADDR !== 16'h0011 || C_PCWrite !== 1'b0 || bus.IMEM_REQ !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL first_transfer: got valid=%b addr=%h pcwrite=%b req=%b expected 0/0011/0/1", bus.IR_VALID, bus.IMEM_ADDR, C_PCWrite, bus.IMEM_REQ);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_decode_stall();
        int pulses;
        logic [15:0] exp_ir;
        exp_ir = mem_word(16'h0011);
        bus.IR_READY = 1'b0;
        ack_delay = 0;
        step();
        pulses = int'(C_PCWrite);
        tests_run++;
        if (bus.IR_OUT !== exp_ir || bus.IR_VALID !== 1'b1 || PC_IN !== 16'h0012) begin
            tests_failed++;
            $display("[TB] FAIL stall_ack: got ir=%h valid=%b pc_in=%h expected %h/1/0012", bus.IR_OUT, bus.IR_VALID, PC_IN, exp_ir);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            pulses += int'(C_PCWrite);
            tests_run++;
            if (bus.IR_VALID !== 1'b1 || bus.IR_OUT !== exp_ir || bus.IMEM_REQ !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold: cycle %0d got valid=%b ir=%h req=%b expected 1/%h/0", i, bus.IR_VALID, bus.IR_OUT, bus.IMEM_REQ, exp_ir);
            end
        end
        tests_run++;
        if (pulses != 1) begin tests_failed++; $display("[TB] FAIL stall_pcwrite_pulses: got %0d expected 1", pulses); end
        bus.IR_READY = 1'b1;
        step();
        tests_run++;
        if (bus.IR_VALID !== 1'b0 || bus.IMEM_ADDR !== 16'h0012 || bus.IMEM_REQ !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stall_release: got valid=%b addr=%h req=%b expected 0/0012/1", bus.IR_VALID, bus.IMEM_ADDR, bus.IMEM_REQ);
        end
    endtask

    task automatic test_pc_wrap();
        logic [15:0] held_ir;
        held_ir = bus.IR_OUT;
        ack_delay = 5;
        C_Branch = 1'b1;
        BRANCH_TARGET = 16'hFFFF;
        step();
        C_Branch = 1'b0;
        ack_delay = 0;
        step();
        tests_run++;
        if (PC_IN !== 16'hFFFF || C_PCWrite !== 1'b1 || bus.IR_VALID !== 1'b0 || bus.IR_OUT !== held_ir) begin
            tests_failed++;
            $display("[TB] FAIL kill_ack: got pc_in=%h pcwrite=%b valid=%b ir=%h expected ffff/1/0/%h", PC_IN, C_PCWrite, bus.IR_VALID, bus.IR_OUT, held_ir);
        end
        step();
        tests_run++;
        if (bus.IMEM_ADDR !== 16'hFFFF || bus.IMEM_REQ !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_fetch_addr: got addr=%h req=%b expected ffff/1", bus.IMEM_ADDR, bus.IMEM_REQ);
        end
        step();
        tests_run++;
        if (PC_IN !== 16'h0000 || bus.IR_OUT !== mem_word(16'hFFFF)) begin
            tests_failed++;
            $display("[TB] FAIL wrap_pc_in: got pc_in=%h ir=%h expected 0000/%h", PC_IN, bus.IR_OUT, mem_word(16'hFFFF));
        end
        step();
        tests_run++;
        if (bus.IMEM_ADDR !== 16'h0000) begin tests_failed++; $display("[TB] FAIL wrap_next_addr: got %h expected 0000", bus.IMEM_ADDR); end
    endtask

    task automatic test_branch_kill();
        int pulses;
        int valid_seen;
        logic [15:0] held_ir;
        held_ir = bus.IR_OUT;
        pulses = 0;
        valid_seen = 0;
        ack_delay = 3;
        C_Branch = 1'b1;
        BRANCH_TARGET = 16'h0200;
        step();
        C_Branch = 1'b0;
        pulses += int'(C_PCWrite);
        valid_seen += int'(bus.IR_VALID);
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(C_PCWrite);
            valid_seen += int'(bus.IR_VALID);
        end
        tests_run++;
        if (PC_IN !== 16'h0200 || C_PCWrite !== 1'b1 || bus.IR_OUT !== held_ir) begin
            tests_failed++;
            $display("[TB] FAIL branch_kill_ack: got pc_in=%h pcwrite=%b ir=%h expected 0200/1/%h", PC_IN, C_PCWrite, bus.IR_OUT, held_ir);
        end
        step();
        pulses += int'(C_PCWrite);
        valid_seen += int'(bus.IR_VALID);
        tests_run++;
        if (pulses != 1 || valid_seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL branch_kill_pulses: got pulses=%0d valid_cycles=%0d expected 1/0", pulses, valid_seen);
        end
        tests_run++;
        if (bus.IMEM_ADDR !== 16'h0200 || bus.IMEM_REQ !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL branch_kill_addr: got addr=%h req=%b expected 0200/1", bus.IMEM_ADDR, bus.IMEM_REQ);
        end
    endtask

    task automatic test_branch_on_transfer();
        logic [15:0] delivered;
        ack_delay = 0;
        bus.IR_READY = 1'b0;
        step();
        bus.IR_READY = 1'b1;
        C_Branch = 1'b1;
        BRANCH_TARGET = 16'h0345;
        delivered = (bus.IR_VALID === 1'b1) ? bus.IR_OUT : 16'hxxxx;
        step();
        C_Branch = 1'b0;
        tests_run++;
        if (delivered !== mem_word(16'h0200)) begin
            tests_failed++;
            $display("[TB] FAIL branch_xfer_data: got %h expected %h", delivered, mem_word(16'h0200));
        end
        tests_run++;
        if (bus.IR_VALID !== 1'b0 || C_PCWrite !== 1'b1 || PC_IN !== 16'h0345) begin
            tests_failed++;
            $display("[TB] FAIL branch_xfer_state: got valid=%b pcwrite=%b pc_in=%h expected 0/1/0345", bus.IR_VALID, C_PCWrite, PC_IN);
        end
        step();
        tests_run++;
        if (bus.IMEM_ADDR !== 16'h0345 || bus.IMEM_REQ !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL branch_xfer_addr: got addr=%h req=%b expected 0345/1", bus.IMEM_ADDR, bus.IMEM_REQ);
        end
    endtask

    task automatic test_async_reset();
        ack_delay = 5;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.IMEM_REQ !== 1'b0 || PC_IN !== RV || C_PCWrite !== 1'b0 || bus.IR_VALID !== 1'b0 || bus.IR_OUT !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got req=%b pc_in=%h pcwrite=%b valid=%b ir=%h expected 0/%h/0/0/0000",
                     bus.IMEM_REQ, PC_IN, C_PCWrite, bus.IR_VALID, bus.IR_OUT, RV);
        end
        bus.IMEM_ACK  = 1'b1;
        bus.IMEM_DATA = 16'hDEAD;
        @(posedge clk);
        #1;
        bus.IMEM_ACK = 1'b0;
        tests_run++;
        if (bus.IR_VALID !== 1'b0 || bus.IR_OUT !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ignores_ack: got valid=%b ir=%h expected 0/0000", bus.IR_VALID, bus.IR_OUT);
        end
        rst_n = 1'b1;
        step();
        tests_run++;
        if (C_PCWrite !== 1'b1 || PC_IN !== RV) begin
            tests_failed++;
            $display("[TB] FAIL reboot_write: got pcwrite=%b pc_in=%h expected 1/%h", C_PCWrite, PC_IN, RV);
        end
        step();
        tests_run++;
        if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== RV) begin
            tests_failed++;
            $display("[TB] FAIL reboot_fetch: got req=%b addr=%h expected 1/%h", bus.IMEM_REQ, bus.IMEM_ADDR, RV);
        end
    endtask

    // Randomized traffic checked against program order: every instruction
    // decode accepts must be the memory word at the next address in flow,
    // where flow advances by one per accepted instruction and jumps on branch.
    task automatic test_random_stream();
        logic [15:0] exp_addr;
        logic [15:0] got;
        logic [15:0] tgt;
        logic        xfer;
        logic        br;
        int          deliveries;
        deliveries = 0;
        C_Branch = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_addr = RV;
        for (int i = 0; i < 400; i++) begin
            bus.IR_READY = ($urandom_range(0, 9) < 6);
            if (!bus.IMEM_REQ) ack_delay = int'($urandom_range(0, 3));
            C_Branch = (i >= 1) && ($urandom_range(0, 9) == 0);
            BRANCH_TARGET = 16'($urandom);
            xfer = bus.IR_VALID && bus.IR_READY;
            got  = bus.IR_OUT;
            br   = C_Branch;
            tgt  = BRANCH_TARGET;
            step();
            if (xfer) begin
                deliveries++;
                tests_run++;
                if (got !== mem_word(exp_addr)) begin
                    tests_failed++;
                    $display("[TB] FAIL random_delivery: cycle %0d got %h expected %h (addr %h)", i, got, mem_word(exp_addr), exp_addr);
                end
                exp_addr = exp_addr + 16'd1;
            end
            if (br) exp_addr = tgt;
        end
        C_Branch = 1'b0;
        tests_run++;
        if (deliveries < 20) begin tests_failed++; $display("[TB] FAIL random_liveness: got %0d deliveries expected at least 20", deliveries); end
    endtask

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n         = 1'b1;
        C_Branch      = 1'b0;
        BRANCH_TARGET = 16'h0000;
        bus.IMEM_ACK  = 1'b0;
        bus.IMEM_DATA = 16'h0000;
        bus.IR_READY  = 1'b1;
        test_reset();
        test_first_fetch();
        test_decode_stall();
        test_pc_wrap();
        test_branch_kill();
        test_branch_on_transfer();
        test_async_reset();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
